// File: rtl/zx_paging_ctrl.sv
// ZX Spectrum side paging and decode controller for the Timex FDD interface.
// A synchronous four-state paging FSM is driven by M1 fetch traps and a
// control port. Memory and FDC selects are decoded combinationally from the
// raw bus, qualified by the registered paging state.
module zx_paging_ctrl #(
  parameter int                    NUM_TRAPS      = 2,
  parameter logic [NUM_TRAPS*16-1:0] TRAP_ADDRS   = {16'h0008, 16'h0000},
  parameter logic [15:0]           UNPAGE_ADDR    = 16'h0604,
  parameter logic [15:0]           UNPAGE_MASK    = 16'hFFFF,
  parameter logic [7:0]            PORT_ADDR      = 8'h2C,
  parameter logic [7:0]            PORT_MASK      = 8'h3C,
  parameter logic                  CTRL_SUB       = 1'b1,
  parameter int                    RAM_BANKS      = 4,
  parameter int                    DELAYED_PAGEIN = 1,
  localparam int                   BANK_W         = (RAM_BANKS > 1) ? $clog2(RAM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic [7:0]        d_in,
  input  logic              n_mreq,
  input  logic              n_iorq,
  input  logic              n_rd,
  input  logic              n_wr,
  input  logic              n_m1,
  output logic              zx_romcs,
  output logic              n_rom_cs,
  output logic              n_ram_cs,
  output logic [BANK_W-1:0] ram_bank,
  output logic              n_fdc_rd,
  output logic              n_fdc_wr,
  output logic              paged
);

  typedef enum logic [1:0] {
    ST_UNPAGED = 2'd0,
    ST_ARM_IN  = 2'd1,
    ST_PAGED   = 2'd2,
    ST_ARM_OUT = 2'd3
  } state_t;

  // Synchroniser bit order: {m1, wr, rd, iorq, mreq}, all active low.
  logic [4:0] pins;
  logic [4:0] sync_p0, sync_p1;
  logic [1:0] edge_p2;            // {wr, mreq} one clock behind sync_p1
  logic       mreq_fall_p3, mreq_rise_p3, wr_fall_p3, wr_rise_p3;

  logic       mreq_s, iorq_s, rd_s, wr_s, m1_s;

  logic       trap_hit, unpage_hit;
  logic       tag_vld_p4, trap_tag_p4, unpage_tag_p4;

  logic       ctrl_addr, port_hit, fdc_sel;
  logic       ctrl_pend_p4, ctrl_wr;
  logic [1:0] ctrl_force_p4;      // {force in, force out}
  logic       ctrl_wp_p4;
  logic [BANK_W-1:0] ctrl_bank_p4;
  logic       wp;

  state_t     state, state_nxt;
  logic       paged_nxt;

  // Only some data bits carry control fields; the rest are don't-care.
  logic       d_in_unused;
  assign d_in_unused = ^d_in;

  assign pins   = {n_m1, n_wr, n_rd, n_iorq, n_mreq};
  assign mreq_s = sync_p1[0];
  assign iorq_s = sync_p1[1];
  assign rd_s   = sync_p1[2];
  assign wr_s   = sync_p1[3];
  assign m1_s   = sync_p1[4];

  // Two-flop synchronisers plus registered edge pulses (3 clk pin-to-pulse).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0      <= 5'h1F;
      sync_p1      <= 5'h1F;
      edge_p2      <= 2'b11;
      mreq_fall_p3 <= 1'b0;
      mreq_rise_p3 <= 1'b0;
      wr_fall_p3   <= 1'b0;
      wr_rise_p3   <= 1'b0;
    end else begin
      sync_p0      <= pins;
      sync_p1      <= sync_p0;
      edge_p2      <= {wr_s, mreq_s};
      mreq_fall_p3 <= edge_p2[0] & ~mreq_s;
      mreq_rise_p3 <= ~edge_p2[0] & mreq_s;
      wr_fall_p3   <= edge_p2[1] & ~wr_s;
      wr_rise_p3   <= ~edge_p2[1] & wr_s;
    end
  end

  // Classify the current address against the trap list and page-out window.
  always_comb begin
    trap_hit = 1'b0;
    for (int i = 0; i < NUM_TRAPS; i++) begin
      if (a == TRAP_ADDRS[i*16 +: 16]) trap_hit = 1'b1;
    end
    unpage_hit = (((a ^ UNPAGE_ADDR) & UNPAGE_MASK) == 16'h0000);
  end

  // Fetch tag: strobe is control, the hit classes are data sampled with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_vld_p4 <= 1'b0;
    else     tag_vld_p4 <= mreq_fall_p3 & ~m1_s;
  end

  // Hit classes captured at the M1 fetch falling edge.
  always_ff @(posedge clk) begin
    if (mreq_fall_p3) begin
      trap_tag_p4   <= trap_hit;
      unpage_tag_p4 <= unpage_hit;
    end
  end

  assign ctrl_addr = (((a[7:0] ^ PORT_ADDR) & PORT_MASK) == 8'h00) && (a[6] == CTRL_SUB);
  assign ctrl_wr   = wr_rise_p3 & ctrl_pend_p4;

  // Arm a control write at the WR falling edge of a qualifying I/O write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ctrl_pend_p4 <= 1'b0;
    else if (wr_fall_p3) ctrl_pend_p4 <= ~iorq_s & m1_s & rd_s & ctrl_addr;
    else if (wr_rise_p3) ctrl_pend_p4 <= 1'b0;
  end

  // Control data sampled at the WR falling edge, committed at the rising edge.
  always_ff @(posedge clk) begin
    if (wr_fall_p3) begin
      ctrl_force_p4 <= d_in[7:6];
      ctrl_wp_p4    <= d_in[5];
      ctrl_bank_p4  <= (RAM_BANKS > 1) ? d_in[BANK_W-1:0] : '0;
    end
  end

  // Write-protect and bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= 1'b0;
      ram_bank <= '0;
    end else if (ctrl_wr) begin
      wp       <= ctrl_wp_p4;
      ram_bank <= ctrl_bank_p4;
    end
  end

  // Paging state register; paged is registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_UNPAGED;
      paged <= 1'b0;
    end else begin
      state <= state_nxt;
      paged <= paged_nxt;
    end
  end

  // Next-state: trap/unpage tags and MREQ rise, overridden by forced writes.
  always_comb begin
    state_nxt = state;
    paged_nxt = 1'b0;
    case (state)
      ST_UNPAGED: if (tag_vld_p4 && trap_tag_p4)
                    state_nxt = (DELAYED_PAGEIN != 0) ? ST_ARM_IN : ST_PAGED;
      ST_ARM_IN:  if (mreq_rise_p3) state_nxt = ST_PAGED;
      ST_PAGED:   if (tag_vld_p4 && unpage_tag_p4) state_nxt = ST_ARM_OUT;
      ST_ARM_OUT: if (mreq_rise_p3) state_nxt = ST_UNPAGED;
      default:    state_nxt = ST_UNPAGED;
    endcase
    if (ctrl_wr) begin
      if (ctrl_force_p4 == 2'b10)      state_nxt = ST_PAGED;
      else if (ctrl_force_p4 == 2'b01) state_nxt = ST_UNPAGED;
    end
    paged_nxt = (state_nxt == ST_PAGED) || (state_nxt == ST_ARM_OUT);
  end

  assign zx_romcs = paged;

  assign n_rom_cs = ~(paged & ~n_mreq & (a[15:13] == 3'b000));
  assign n_ram_cs = ~(paged & ~n_mreq & (a[15:13] == 3'b001) & ~(wp & ~n_wr));

  // M1 high excludes interrupt acknowledge from port decoding.
  assign port_hit = ~n_iorq & n_m1 & (((a[7:0] ^ PORT_ADDR) & PORT_MASK) == 8'h00);
  assign fdc_sel  = port_hit & (a[6] != CTRL_SUB);
  assign n_fdc_rd = ~(fdc_sel & ~n_rd);
  assign n_fdc_wr = ~(fdc_sel & ~n_wr);

endmodule

// File: tb/tb_zx_paging_ctrl.sv
// Bench for zx_paging_ctrl: bus-cycle tasks push expectations into a
// scoreboard queue; a monitor on the falling clock edge pops and compares.
module tb_zx_paging_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        n_mreq, n_iorq, n_rd, n_wr, n_m1;
  logic        zx_romcs, n_rom_cs, n_ram_cs, n_fdc_rd, n_fdc_wr, paged;
  logic [1:0]  ram_bank;

  zx_paging_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .d_in     (d_in),
    .n_mreq   (n_mreq),
    .n_iorq   (n_iorq),
    .n_rd     (n_rd),
    .n_wr     (n_wr),
    .n_m1     (n_m1),
    .zx_romcs (zx_romcs),
    .n_rom_cs (n_rom_cs),
    .n_ram_cs (n_ram_cs),
    .ram_bank (ram_bank),
    .n_fdc_rd (n_fdc_rd),
    .n_fdc_wr (n_fdc_wr),
    .paged    (paged)
  );

  always #5 clk = ~clk;

  typedef enum int {F_PAGED, F_ROMCS, F_NROM, F_NRAM, F_BANK, F_FDCRD, F_FDCWR} field_t;
  typedef struct {
    field_t     f;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the observable paging state after each whole bus cycle.
  bit         m_paged;
  bit         m_wp;
  logic [1:0] m_bank;
  logic [15:0] trap_list [2] = '{16'h0000, 16'h0008};

  function automatic logic [7:0] observe(field_t f);
    case (f)
      F_PAGED: return {7'd0, paged};
      F_ROMCS: return {7'd0, zx_romcs};
      F_NROM:  return {7'd0, n_rom_cs};
      F_NRAM:  return {7'd0, n_ram_cs};
      F_BANK:  return {6'd0, ram_bank};
      F_FDCRD: return {7'd0, n_fdc_rd};
      default: return {7'd0, n_fdc_wr};
    endcase
  endfunction

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] act;
    while (sb_q.size() > 0) begin
      c   = sb_q.pop_front();
      act = observe(c.f);
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", c.name, act, c.exp, $time);
      end
    end
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $finish;
  end

  task automatic push(input field_t f, input logic [7:0] e, input string n);
    chk_t c;
    c.f = f; c.exp = e; c.name = n;
    sb_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input field_t f, input logic [7:0] e, input int max_clk, input string n);
    int k;
    k = 0;
    while (observe(f) !== e && k < max_clk) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (observe(f) !== e) begin
      n_fail++;
      $display("FAIL %s: wait expired after %0d clk, got %0h, expected %0h (t=%0t)",
               n, max_clk, observe(f), e, $time);
    end
  endtask

  function automatic bit is_trap(input logic [15:0] addr);
    foreach (trap_list[i]) if (trap_list[i] == addr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fetch_done(input logic [15:0] addr);
    if (!m_paged && is_trap(addr))             m_paged = 1'b1;
    else if (m_paged && addr == 16'h0604)      m_paged = 1'b0;
  endfunction

  function automatic void model_ctrl(input logic [7:0] d);
    if (d[7] && !d[6])      m_paged = 1'b1;
    else if (d[6] && !d[7]) m_paged = 1'b0;
    m_wp   = d[5];
    m_bank = d[1:0];
  endfunction

  function automatic logic [7:0] exp_nrom(input logic [15:0] addr);
    return {7'd0, !(m_paged && addr < 16'h2000)};
  endfunction

  function automatic logic [7:0] exp_nram(input logic [15:0] addr, input bit wr);
    return {7'd0, !(m_paged && addr >= 16'h2000 && addr < 16'h4000 && !(m_wp && wr))};
  endfunction

  // Memory cycle (M1 fetch, read or write) with checks mid-cycle and after.
  task automatic mem_cycle(input logic [15:0] addr, input bit m1, input bit wr);
    a    = addr;
    n_m1 = !m1;
    d_in = 8'($urandom);
    tick(1);
    n_mreq = 1'b0;
    if (!wr) n_rd = 1'b0;
    tick(2);
    if (wr) n_wr = 1'b0;
    tick(5);
    push(F_PAGED, {7'd0, m_paged}, "paged_during_cycle");
    push(F_NROM, exp_nrom(addr), "n_rom_cs");
    push(F_NRAM, exp_nram(addr, wr), "n_ram_cs");
    tick(1);
    n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
    if (m1) model_fetch_done(addr);
    tick(4);
    push(F_PAGED, {7'd0, m_paged}, "paged_after_cycle");
    push(F_ROMCS, {7'd0, m_paged}, "zx_romcs_after_cycle");
    tick(3);
  endtask

  // I/O read, write, or interrupt acknowledge.
  task automatic io_cycle(input logic [7:0] port, input bit wr, input logic [7:0] d, input bit inta);
    bit hit, fdc;
    a    = {8'($urandom), port};
    d_in = d;
    if (inta) n_m1 = 1'b0;
    tick(1);
    n_iorq = 1'b0;
    if (!inta) begin
      if (wr) n_wr = 1'b0;
      else    n_rd = 1'b0;
    end
    tick(4);
    hit = !inta && (port[5:2] == 4'b1011);
    fdc = hit && !port[6];
    push(F_FDCRD, {7'd0, !(fdc && !wr)}, "n_fdc_rd");
    push(F_FDCWR, {7'd0, !(fdc && wr)}, "n_fdc_wr");
    tick(1);
    n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
    if (hit && !fdc && wr) model_ctrl(d);
    tick(6);
    push(F_PAGED, {7'd0, m_paged}, "paged_after_io");
    push(F_BANK, {6'd0, m_bank}, "ram_bank");
  endtask

  function automatic logic [7:0] pick_port();
    case ($urandom_range(0, 3))
      0:       return 8'h6C;
      1:       return 8'h2C;
      2:       return 8'hEC;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    a = 16'h0000; d_in = 8'h00;
    n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
    m_paged = 1'b0; m_wp = 1'b0; m_bank = 2'd0;
    tick(3);
    n_checks++;
    if (paged !== 1'b0 || zx_romcs !== 1'b0 || ram_bank !== 2'd0 ||
        n_rom_cs !== 1'b1 || n_ram_cs !== 1'b1 || n_fdc_rd !== 1'b1 || n_fdc_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: paged=%b zx_romcs=%b ram_bank=%0d n_rom_cs=%b n_ram_cs=%b n_fdc_rd=%b n_fdc_wr=%b (t=%0t)",
               paged, zx_romcs, ram_bank, n_rom_cs, n_ram_cs, n_fdc_rd, n_fdc_wr, $time);
    end
    push(F_PAGED, 8'd0, "reset_paged");
    push(F_ROMCS, 8'd0, "reset_zx_romcs");
    push(F_BANK,  8'd0, "reset_bank");
    push(F_NROM,  8'd1, "reset_n_rom_cs");
    push(F_NRAM,  8'd1, "reset_n_ram_cs");
    push(F_FDCRD, 8'd1, "reset_n_fdc_rd");
    push(F_FDCWR, 8'd1, "reset_n_fdc_wr");
    tick(1);
    rst = 1'b0;
    tick(3);

    // Delayed page-in on trap 0x0000, then ROM visible.
    mem_cycle(16'h0000, 1'b1, 1'b0);
    wait_level(F_PAGED, 8'd1, 4, "wait_page_in");
    mem_cycle(16'h1234, 1'b0, 1'b0);
    // Page-out window.
    mem_cycle(16'h0604, 1'b1, 1'b0);
    wait_level(F_PAGED, 8'd0, 4, "wait_page_out");
    mem_cycle(16'h0000, 1'b0, 1'b0);
    // Non-M1 access to a trap address, then the real fetch.
    mem_cycle(16'h0008, 1'b0, 1'b0);
    mem_cycle(16'h0008, 1'b1, 1'b0);
    // Unpage with a forced write, then forced page-in with wp and bank 3.
    io_cycle(8'h6C, 1'b1, 8'h40, 1'b0);
    io_cycle(8'h6C, 1'b1, 8'hA3, 1'b0);
    mem_cycle(16'h2800, 1'b0, 1'b1);
    mem_cycle(16'h2800, 1'b0, 1'b0);
    // FDC read strobe, then interrupt acknowledge on the same low byte.
    io_cycle(8'h2C, 1'b0, 8'h00, 1'b0);
    io_cycle(8'h2C, 1'b0, 8'h00, 1'b1);
    io_cycle(8'h2C, 1'b1, 8'h55, 1'b0);

    // Reset while armed for page-in.
    io_cycle(8'h6C, 1'b1, 8'h43, 1'b0);
    a = 16'h0000; n_m1 = 1'b0;
    tick(1);
    n_mreq = 1'b0; n_rd = 1'b0;
    tick(7);
    rst = 1'b1;
    m_paged = 1'b0; m_wp = 1'b0; m_bank = 2'd0;
    push(F_PAGED, 8'd0, "rst_arm_paged");
    push(F_BANK,  8'd0, "rst_arm_bank");
    push(F_ROMCS, 8'd0, "rst_arm_zx_romcs");
    tick(1);
    n_mreq = 1'b1; n_rd = 1'b1; n_m1 = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(8);
    wait_level(F_PAGED, 8'd0, 2, "wait_rst_arm_unpaged");
    mem_cycle(16'h0604, 1'b1, 1'b0);
    mem_cycle(16'h0000, 1'b0, 1'b0);

    // Randomised traffic.
    for (int it = 0; it < 150; it++) begin
      int          kind;
      int          sel;
      logic [15:0] addr;
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          sel  = $urandom_range(0, 3);
          addr = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h0008 :
                 (sel == 2) ? 16'h0604 : 16'($urandom);
          mem_cycle(addr, 1'b1, 1'b0);
        end
        1: mem_cycle(16'($urandom_range(0, 16'h5FFF)), 1'b0, 1'b0);
        2: mem_cycle(16'($urandom_range(0, 16'h5FFF)), 1'b0, 1'b1);
        3: io_cycle(pick_port(), 1'b1, 8'($urandom), 1'b0);
        4: io_cycle(pick_port(), 1'b0, 8'h00, 1'b0);
        default: io_cycle(pick_port(), 1'b0, 8'h00, 1'b1);
      endcase
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
